// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data_mem arbitration slice: memory geometry,
// arbiter priority states and the port identifiers carried by the read-return
// tag.
// -----------------------------------------------------------------------------
package data_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  typedef enum logic {
    P_PRIO = 1'b0,
    D_PRIO = 1'b1
  } arb_state_t;

  localparam logic PORT_P = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/data_mem_rd_return.sv
// -----------------------------------------------------------------------------
// data_mem_rd_return
// Tracks the single outstanding read issued to data_mem, raises the owning
// port's rvalid in the following cycle, and keeps a per-port hold register so
// each port's rdata stays stable between its own returns.
//
// Ports
//   clock         system clock, rising edge
//   reset_n       synchronous active-low reset
//   rd_issue      a read was granted this cycle
//   rd_port       owner of that read (PORT_P / PORT_D)
//   mem_out_data  registered read data from data_mem
//   p_rvalid      pipeline read data valid
//   p_rdata       pipeline read data
//   d_rvalid      debug read data valid
//   d_rdata       debug read data
// -----------------------------------------------------------------------------
module data_mem_rd_return
  import data_mem_pkg::*;
#(
  parameter int DATA_W = data_mem_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_issue,
  input  logic              rd_port,
  input  logic [DATA_W-1:0] mem_out_data,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata
);

  logic              rd_vld_q;
  logic              rd_tag_q;
  logic [DATA_W-1:0] p_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  // A return already in flight is suppressed while reset is asserted so that
  // it is never presented to the requester.
  always_comb begin
    p_rvalid = reset_n & rd_vld_q & (rd_tag_q == PORT_P);
    d_rvalid = reset_n & rd_vld_q & (rd_tag_q == PORT_D);
    p_rdata  = p_rvalid ? mem_out_data : p_hold_q;
    d_rdata  = d_rvalid ? mem_out_data : d_hold_q;
  end

  // Return stage: tag registered at the grant edge, data captured at the end
  // of the return cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= PORT_P;
      p_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      rd_vld_q <= rd_issue;
      rd_tag_q <= rd_port;
      if (p_rvalid) p_hold_q <= mem_out_data;
      if (d_rvalid) d_hold_q <= mem_out_data;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data_mem between the pipeline MEM stage (P, fixed
// priority) and the debug/loader port (D). A starvation counter hands D one
// guaranteed grant after STARVE_LIMIT consecutive refused cycles.
//
// Ports
//   clock, reset_n                    clock / synchronous active-low reset
//   p_req, p_write, p_addr, p_wdata   pipeline request
//   p_gnt, p_stall                    pipeline grant (comb) / stall
//   p_rvalid, p_rdata                 pipeline read return
//   d_req, d_write, d_addr, d_wdata   debug request
//   d_gnt                             debug grant (comb)
//   d_rvalid, d_rdata                 debug read return
//   mem_address, mem_in_data,
//   mem_write                         to data_mem
//   mem_out_data                      from data_mem (registered read)
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W       = data_mem_pkg::ADDR_W,
  parameter int DATA_W       = data_mem_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              p_req,
  input  logic              p_write,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_stall,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out_data
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT - 1);

  arb_state_t state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       d_refused;
  logic       rd_issue;
  logic       rd_port;

  // Grants: nothing is granted while reset is held, so no write can slip
  // into the memory during reset.
  always_comb begin
    p_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset_n) begin
      case (state_q)
        P_PRIO: begin
          p_gnt = p_req;
          d_gnt = d_req & ~p_req;
        end
        D_PRIO: begin
          d_gnt = d_req;
          p_gnt = p_req & ~d_req;
        end
        default: begin
          p_gnt = 1'b0;
          d_gnt = 1'b0;
        end
      endcase
    end
  end

  assign p_stall   = p_req & ~p_gnt;
  assign d_refused = d_req & ~d_gnt;

  // Next state and starvation count. D_PRIO lasts one cycle at most: D is
  // either granted there or has withdrawn its request.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (!d_refused) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + 8'd1;
    end
    case (state_q)
      P_PRIO: if (d_refused && (starve_q == STARVE_MAX)) state_d = D_PRIO;
      D_PRIO: if (d_gnt || !d_req) state_d = P_PRIO;
      default: state_d = P_PRIO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= P_PRIO;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Memory mux: with no grant, P's address is presented as a harmless read.
  always_comb begin
    if (d_gnt) begin
      mem_address = d_addr;
      mem_in_data = d_wdata;
      mem_write   = d_write;
    end else begin
      mem_address = p_addr;
      mem_in_data = p_wdata;
      mem_write   = p_gnt & p_write;
    end
  end

  assign rd_issue = (p_gnt & ~p_write) | (d_gnt & ~d_write);
  assign rd_port  = d_gnt ? PORT_D : PORT_P;

  data_mem_rd_return #(
    .DATA_W (DATA_W)
  ) u_rd_return (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_issue     (rd_issue),
    .rd_port      (rd_port),
    .mem_out_data (mem_out_data),
    .p_rvalid     (p_rvalid),
    .p_rdata      (p_rdata),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata)
  );

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data_mem (2048 x 32, write or registered read on clock rising edge) between two requesters: the pipeline MEM stage (port P) and the debug/loader port (port D).
- P has fixed priority.
- A starvation counter guarantees D a grant after STARVE_LIMIT consecutive refused cycles.
- The block drives the memory address, write data and write strobe, and steers read data back to the winning port with a valid pulse.
- It also produces the pipeline stall signal.

Parameters:
ADDR_W, 11, memory word-address width.
DATA_W, 32, data width.
STARVE_LIMIT, 8, consecutive refused D-request cycles before D is forced to win (range 1..255).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  synchronous, active-low reset.
p_req  in  1  pipeline access request.
p_write  in  1  1 = write, 0 = read.
p_addr  in  ADDR_W  pipeline word address.
p_wdata  in  DATA_W  pipeline write data.
p_gnt  out  1  pipeline access accepted this cycle (combinational).
p_stall  out  1  p_req & ~p_gnt.
p_rvalid  out  1  pipeline read data valid (registered).
p_rdata  out  DATA_W  pipeline read data.
d_req, d_write, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: same as the p_ ports, for the debug port (no stall output).
mem_address  out  ADDR_W  to data_mem address.
mem_in_data  out  DATA_W  to data_mem in_data.
mem_write  out  1  to data_mem write.
mem_out_data  in  DATA_W  from data_mem out_data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset state while reset_n=0 at a rising edge:
  - state = P_PRIO, starve_cnt = 0.
  - p_rvalid = d_rvalid = 0.
  - p_rdata = d_rdata = 0.
  - Grants are forced 0 while reset_n=0, so mem_write = 0.
  - Memory contents are untouched.
- FSM states:
  - P_PRIO: p_gnt = p_req; d_gnt = d_req & ~p_req.
  - D_PRIO: d_gnt = d_req; p_gnt = p_req & ~d_req.
- FSM transitions:
  - P_PRIO -> D_PRIO when d_req & ~d_gnt and starve_cnt == STARVE_LIMIT-1.
  - D_PRIO -> P_PRIO after any cycle with d_gnt = 1, or when d_req drops.
- starve_cnt (8-bit):
  - Increments each cycle with d_req & ~d_gnt, saturating at STARVE_LIMIT-1.
  - Clears on d_gnt or on ~d_req.
- Memory mux (combinational from the granted port):
  - mem_address, mem_in_data = granted port's addr/wdata.
  - mem_write = granted write bit.
  - With no grant: mem_write = 0 and address holds P's address (harmless read).
- Read latency: a read granted in cycle N gives the port's rvalid = 1 for exactly one cycle, N+1.
  - In cycle N+1, rdata = mem_out_data (combinational pass-through).
  - At the end of N+1 the value is captured into a per-port hold register.
  - Outside rvalid cycles, rdata = hold register, so it stays stable even while the other port reads.
- Writes produce no rvalid. The hold registers are unchanged by writes.
- Back-to-back: one grant per cycle. A grant in N+1 is legal while N's rvalid is returning; return tags are registered, so there are no collisions.
- Both ports at the same address in the same cycle: only the winner accesses; the loser retries next cycle.
- Requester rules: requesters hold req/addr/wdata/write stable until gnt. Deassertion without gnt is allowed (abort).
- Reset mid-operation: a pending rvalid is dropped and never issued. A write granted in the same cycle as reset_n=0 is not performed.
- Address wrap: none. Addresses are used modulo 2^ADDR_W, exactly as data_mem.

Decomposition:
- Shared package data_mem_pkg: ADDR_W/DATA_W constants, arb_state_t enum (P_PRIO, D_PRIO), port-id constants PORT_P=0 and PORT_D=1.
- One sub-module, data_mem_rd_return: the registered return tag, the rvalid pulses and the two rdata hold registers.
- The grant FSM and starve counter stay in the top.

Test Plan:
1. Reset then P read addr 5 (preloaded 0xDEADBEEF): p_gnt in N, p_rvalid=1 and p_rdata=0xDEADBEEF in N+1, rdata held afterwards.
2. P write addr 10 = 0x12345678, then D read addr 10: d_gnt in the cycle after P's grant, d_rvalid next cycle with 0x12345678; p_stall = 0 throughout.
3. p_req and d_req held continuously, STARVE_LIMIT=8: D is granted exactly on the 9th cycle. p_stall = 1 in that cycle only, then P wins again. Pattern repeats every 9 cycles.
4. Interleaved reads: P reads addr 1 (0x11), D reads addr 2 (0x22) the next cycle. p_rdata stays 0x11 after D's return; d_rdata = 0x22.
5. reset_n=0 in the cycle after a granted P read: no p_rvalid, p_rdata = 0, FSM = P_PRIO, starve_cnt = 0.
6. D request aborted after 5 refused cycles, then re-raised: starve_cnt restarts from 0, and 8 more refused cycles are required before the forced D grant.
